// File: rtl/full_subtractor_pipe_16bits.sv
// Registered 16-bit subtractor (diff = a - b - b_in) with the borrow chain split over two
// pipeline stages and valid/ready handshakes on input and output.
module full_subtractor_pipe_16bits #(
   parameter int WIDTH = 16,
   parameter int SPLIT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             ovf
);

   localparam int HI = WIDTH - SPLIT;

   logic             r_v0;
   logic [WIDTH-1:0] r_a0;
   logic [WIDTH-1:0] r_b0;
   logic             r_bin0;

   logic             r_v1;
   logic [SPLIT-1:0] r_diffLo;
   logic             r_midBorrow;
   logic [HI-1:0]    r_aHi;
   logic [HI-1:0]    r_bHi;

   logic             r_v2;
   logic [WIDTH-1:0] r_diff;
   logic             r_bOut;
   logic             r_ovf;

   logic             w_adv0;
   logic             w_adv1;
   logic             w_adv2;
   logic [SPLIT-1:0] w_diffLo;
   logic             w_midBorrow;
   logic [HI-1:0]    w_diffHi;
   logic             w_bOut;
   logic             w_ovf;

   // A stage may take new data when it is empty or its contents move on this edge.
   assign w_adv2   = !r_v2 | out_ready;
   assign w_adv1   = !r_v1 | w_adv2;
   assign w_adv0   = !r_v0 | w_adv1;
   assign in_ready = w_adv0;

   always_comb begin : lowChain
      logic bor;
      bor      = r_bin0;
      w_diffLo = '0;
      for (int i = 0; i < SPLIT; i++) begin
         w_diffLo[i] = r_a0[i] ^ r_b0[i] ^ bor;
         bor         = (~r_a0[i] & r_b0[i]) | (~(r_a0[i] ^ r_b0[i]) & bor);
      end
      w_midBorrow = bor;
   end

   // Upper half resumes the ripple from the borrow registered out of the low half.
   always_comb begin : highChain
      logic bor;
      bor      = r_midBorrow;
      w_diffHi = '0;
      for (int i = 0; i < HI; i++) begin
         w_diffHi[i] = r_aHi[i] ^ r_bHi[i] ^ bor;
         bor         = (~r_aHi[i] & r_bHi[i]) | (~(r_aHi[i] ^ r_bHi[i]) & bor);
      end
      w_bOut = bor;
   end

   assign w_ovf = (r_aHi[HI-1] ^ r_bHi[HI-1]) & (r_aHi[HI-1] ^ w_diffHi[HI-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v0        <= 1'b0;
         r_a0        <= '0;
         r_b0        <= '0;
         r_bin0      <= 1'b0;
         r_v1        <= 1'b0;
         r_diffLo    <= '0;
         r_midBorrow <= 1'b0;
         r_aHi       <= '0;
         r_bHi       <= '0;
         r_v2        <= 1'b0;
         r_diff      <= '0;
         r_bOut      <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         if (w_adv0) begin
            r_v0 <= in_valid;
            if (in_valid) begin
               r_a0   <= a;
               r_b0   <= b;
               r_bin0 <= b_in;
            end
         end
         if (w_adv1) begin
            r_v1 <= r_v0;
            if (r_v0) begin
               r_diffLo    <= w_diffLo;
               r_midBorrow <= w_midBorrow;
               r_aHi       <= r_a0[WIDTH-1:SPLIT];
               r_bHi       <= r_b0[WIDTH-1:SPLIT];
            end
         end
         if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
               r_diff <= {w_diffHi, r_diffLo};
               r_bOut <= w_bOut;
               r_ovf  <= w_ovf;
            end
         end
      end
   end

   assign out_valid = r_v2;
   assign diff      = r_diff;
   assign b_out     = r_bOut;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_full_subtractor_pipe_16bits.sv
// Scoreboard bench for full_subtractor_pipe_16bits: directed operands with hand-computed
// results pushed on acceptance, popped and compared by an independent output monitor.
module tb_full_subtractor_pipe_16bits;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        b_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        b_out;
   logic        ovf;

   int total = 0;
   int bad   = 0;
   logic [17:0] expQ[$];

   full_subtractor_pipe_16bits dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .b_in     (b_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .diff     (diff),
      .b_out    (b_out),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Result transfers on the coming edge when out_valid & out_ready at the falling edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_result: got %0h expected none",
                     {diff, b_out, ovf});
         end else begin
            checkOutput("result{diff,b_out,ovf}", 32'({diff, b_out, ovf}),
                        32'(expQ.pop_front()));
         end
      end
   end

   task automatic applyStimulus(input logic [15:0] ia, input logic [15:0] ib,
                                input logic ibin, input logic [15:0] eDiff,
                                input logic eBout, input logic eOvf);
      bit accepted;
      accepted = 0;
      @(posedge clk);
      #1;
      a        = ia;
      b        = ib;
      b_in     = ibin;
      in_valid = 1'b1;
      for (int c = 0; c < 20 && !accepted; c++) begin
         @(negedge clk);
         if (in_ready) begin
            expQ.push_back({eDiff, eBout, eOvf});
            accepted = 1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!accepted) checkOutput("accept_timeout", 32'(0), 32'(1));
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (expQ.size() != 0 && c < 40) begin
         @(negedge clk);
         c++;
      end
      checkOutput("drain_queue_empty", 32'(expQ.size()), 32'(0));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int k;
      int accepts;
      bit took;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      b_in      = 1'b0;

      // Reset asserted before any clock edge: outputs must clear asynchronously.
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
      checkOutput("rst_diff", 32'(diff), 32'(0));
      checkOutput("rst_b_out", 32'(b_out), 32'(0));
      checkOutput("rst_ovf", 32'(ovf), 32'(0));
      checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("idle_out_valid", 32'(out_valid), 32'(0));
      end

      // Basic latency: accepted at edge N, visible after N+2, gone after N+3.
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      a = 16'h1234; b = 16'h0234; b_in = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      checkOutput("lat_in_ready", 32'(in_ready), 32'(1));
      expQ.push_back({16'h1000, 1'b0, 1'b0});
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      checkOutput("lat_valid_n0", 32'(out_valid), 32'(0));
      @(negedge clk);
      checkOutput("lat_valid_n1", 32'(out_valid), 32'(0));
      @(negedge clk);
      checkOutput("lat_valid_n2", 32'(out_valid), 32'(1));
      @(negedge clk);
      checkOutput("lat_valid_n3", 32'(out_valid), 32'(0));

      applyStimulus(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      applyStimulus(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0);
      applyStimulus(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      applyStimulus(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
      applyStimulus(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
      applyStimulus(16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      applyStimulus(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      applyStimulus(16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1);
      applyStimulus(16'hA5F0, 16'h1234, 1'b0, 16'h93BC, 1'b0, 1'b0);
      drain();

      // Backpressure: pipeline fills with three operands, output held.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      k = 0;
      accepts = 0;
      a = 16'd10; b = 16'h0001; b_in = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         took = in_valid && in_ready;
         if (took) begin
            expQ.push_back({a - 16'd1, 1'b0, 1'b0});
            accepts++;
         end
         if (out_valid) checkOutput("bp_hold_diff", 32'(diff), 32'h0009);
         @(posedge clk);
         #1;
         if (took) begin
            k++;
            if (k < 5) a = 16'(10 + k);
            else in_valid = 1'b0;
         end
      end
      checkOutput("bp_accepts", 32'(accepts), 32'(3));
      checkOutput("bp_in_ready_low", 32'(in_ready), 32'(0));
      checkOutput("bp_out_valid", 32'(out_valid), 32'(1));
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("bp_stream_valid", 32'(out_valid), 32'(1));
         took = in_valid && in_ready;
         if (took) expQ.push_back({a - 16'd1, 1'b0, 1'b0});
         @(posedge clk);
         #1;
         if (took) begin
            k++;
            if (k < 5) a = 16'(10 + k);
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("bp_stream_end_valid", 32'(out_valid), 32'(0));
      checkOutput("bp_all_inputs", 32'(k), 32'(5));
      drain();

      // Reset while two operations are in flight; none may reappear.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      a = 16'h0003; b = 16'h0001; b_in = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 a = 16'h0004;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #2;
      checkOutput("mid_pre_valid", 32'(out_valid), 32'(1));
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_valid", 32'(out_valid), 32'(0));
      checkOutput("mid_rst_diff", 32'(diff), 32'(0));
      checkOutput("mid_rst_in_ready", 32'(in_ready), 32'(1));
      expQ.delete();
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("post_rst_valid", 32'(out_valid), 32'(0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
